// File: rtl/rotl_restore_reg.sv
// rotl_restore_reg
// Captures a word and a rotation amount on LOAD, then rotates the word left
// by one bit per clock until the amount is used up. The result is held on
// Dout with DONE until the consumer acknowledges it. This block undoes the
// right rotation applied by the matching rotate-right PIPO register.
//
// Ports:
//   CLK   in   1      clock, rising edge
//   RST   in   1      asynchronous active-high reset
//   LOAD  in   1      capture Din/AMT (accepted in IDLE and DONE)
//   Din   in   WIDTH  word to capture
//   AMT   in   AW     number of single-bit left rotations, 0..WIDTH-1
//   ACK   in   1      consumer acknowledge of the held result
//   Dout  out  WIDTH  word being rotated, or the final result
//   BUSY  out  1      high while rotating
//   DONE  out  1      high while a finished result is held
module rotl_restore_reg #(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] Din,
  input  logic [AW-1:0]    AMT,
  input  logic             ACK,
  output logic [WIDTH-1:0] Dout,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dout_q;
  logic [AW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dout_rot_d;

  // Single-bit rotate left: the MSB wraps into the LSB.
  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  assign dout_rot_d = rotl1(dout_q);

  // BUSY/DONE are registered copies of the state decode, updated on the same
  // edge as the state so they always match the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      dout_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (LOAD) begin
            dout_q <= Din;
            cnt_q  <= AMT;
            if (AMT == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ROTATE;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else if ((state_q == S_DONE) && ACK) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        S_ROTATE: begin
          dout_q <= dout_rot_d;
          cnt_q  <= cnt_q - 1'b1;
          // Leaving at CNT==1 means the counter never wraps below zero.
          if (cnt_q == AW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Dout = dout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_rotl_restore_reg.sv
// Testbench for rotl_restore_reg: directed vectors with hand-computed
// expectations, plus a per-cycle comparison against a transaction-level model
// that derives Dout as rotate-left(Din, rotations-so-far).
module tb_rotl_restore_reg;

  localparam int W  = 8;
  localparam int AW = $clog2(W);

  logic          CLK;
  logic          RST;
  logic          LOAD;
  logic [W-1:0]  Din;
  logic [AW-1:0] AMT;
  logic          ACK;
  logic [W-1:0]  Dout;
  logic          BUSY;
  logic          DONE;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  rotl_restore_reg #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (LOAD),
    .Din  (Din),
    .AMT  (AMT),
    .ACK  (ACK),
    .Dout (Dout),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: operation phase (0 idle, 1 rotating, 2 done), captured
  // word, requested amount and number of rotations applied so far.
  int           m_phase = 0;
  logic [W-1:0] m_din   = '0;
  int           m_amt   = 0;
  int           m_j     = 0;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int j);
    logic [W-1:0] r;
    if (j == 0) r = v;
    else        r = (v << j) | (v >> (W - j));
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase <= 0;
      m_din   <= '0;
      m_amt   <= 0;
      m_j     <= 0;
    end else if (m_phase == 1) begin
      m_j <= m_j + 1;
      if (m_j + 1 == m_amt) m_phase <= 2;
    end else if (LOAD) begin
      m_din   <= Din;
      m_amt   <= int'(AMT);
      m_j     <= 0;
      m_phase <= (AMT == '0) ? 2 : 1;
    end else if (m_phase == 2 && ACK) begin
      m_phase <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_dout", 32'(Dout), 32'(rotl(m_din, m_j)));
      check("model_busy", 32'(BUSY), 32'(m_phase == 1));
      check("model_done", 32'(DONE), 32'(m_phase == 2));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] d,
                            input logic b, input logic dn);
    check({name, "_dout"}, 32'(Dout), 32'(d));
    check({name, "_busy"}, 32'(BUSY), 32'(b));
    check({name, "_done"}, 32'(DONE), 32'(dn));
  endtask

  task automatic load(input logic [W-1:0] d, input logic [AW-1:0] a);
    LOAD = 1'b1;
    Din  = d;
    AMT  = a;
    tick();
    LOAD = 1'b0;
  endtask

  initial begin
    RST  = 1'b0;
    LOAD = 1'b0;
    Din  = '0;
    AMT  = '0;
    ACK  = 1'b0;

    // Reset asserted mid-cycle takes effect before any clock edge.
    #2 RST = 1'b1;
    #1;
    expect_out("reset_async", 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;
    chk_en = 1'b1;
    tick();
    expect_out("reset_idle", 8'h00, 1'b0, 1'b0);

    // 0xB4 rotated left three times.
    load(8'hB4, 3'd3);
    expect_out("b4_j0", 8'hB4, 1'b1, 1'b0);
    tick();
    expect_out("b4_j1", 8'h69, 1'b1, 1'b0);
    tick();
    expect_out("b4_j2", 8'hD2, 1'b1, 1'b0);
    tick();
    expect_out("b4_j3", 8'hA5, 1'b0, 1'b1);
    tick();
    expect_out("b4_hold", 8'hA5, 1'b0, 1'b1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_out("b4_ack", 8'hA5, 1'b0, 1'b0);
    tick();
    expect_out("b4_idle", 8'hA5, 1'b0, 1'b0);

    // Zero amount goes straight to DONE.
    load(8'h3C, 3'd0);
    expect_out("amt0", 8'h3C, 1'b0, 1'b1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_out("amt0_ack", 8'h3C, 1'b0, 1'b0);

    // Full-range rotation, with a LOAD during ROTATE that must be ignored.
    load(8'h01, 3'd7);
    expect_out("amt7_j0", 8'h01, 1'b1, 1'b0);
    tick();
    LOAD = 1'b1; Din = 8'hFF; AMT = 3'd2;
    ACK  = 1'b1;
    tick();
    LOAD = 1'b0; ACK = 1'b0;
    expect_out("amt7_j2", 8'h04, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    expect_out("amt7_j6", 8'h40, 1'b1, 1'b0);
    tick();
    expect_out("amt7_j7", 8'h80, 1'b0, 1'b1);

    // LOAD and ACK together in DONE: LOAD wins, no idle bubble.
    ACK = 1'b1;
    load(8'h81, 3'd1);
    ACK = 1'b0;
    expect_out("b2b_load", 8'h81, 1'b1, 1'b0);
    tick();
    expect_out("b2b_done", 8'h03, 1'b0, 1'b1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;

    // Reset aborts an operation in progress.
    load(8'hF0, 3'd5);
    tick();
    expect_out("abort_j1", 8'hE1, 1'b1, 1'b0);
    #2 RST = 1'b1;
    #1;
    expect_out("abort_rst", 8'h00, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    tick();
    expect_out("abort_idle", 8'h00, 1'b0, 1'b0);
    load(8'h0F, 3'd4);
    expect_out("post_j0", 8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    expect_out("post_j3", 8'h78, 1'b1, 1'b0);
    tick();
    expect_out("post_j4", 8'hF0, 1'b0, 1'b1);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rotl_restore_reg.md
# rotl_restore_reg

Parallel-in parallel-out rotational left shift register that undoes a right rotation of a captured word. On a synchronous load it captures a word and a rotation amount. It then rotates the word left by one bit per clock until the amount is exhausted, and holds the result with a DONE handshake. It sits on the receiving side of the team's rotate-right PIPO register, restoring words that register rotated right.

## Interface
- WIDTH, 8, data width; power of two, at least 2.
- AW, $clog2(WIDTH), width of the rotation-amount input; derived, not overridden.

- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- LOAD  in  1  synchronous load request; sampled on the rising edge of CLK.
- Din  in  WIDTH  parallel data word to capture.
- AMT  in  AW  number of single-bit left rotations to apply, 0..WIDTH-1.
- ACK  in  1  consumer acknowledge of a completed result.
- Dout  out  WIDTH  parallel output register; the word being rotated or the final result.
- BUSY  out  1  high while rotating.
- DONE  out  1  high while a finished result is held on Dout.

## Operation
- States: IDLE, ROTATE, DONE. BUSY = (state == ROTATE). DONE = (state == DONE). Both are decoded from the state register only (Moore outputs).
- Internal down-counter CNT is AW bits wide.
- **IDLE**
  - LOAD=1: Dout <= Din, CNT <= AMT.
  - If AMT == 0, next state is DONE; otherwise next state is ROTATE.
  - LOAD=0: all registers hold.
  - ACK is ignored.
- **ROTATE**
  - Every edge: Dout <= {Dout[WIDTH-2:0], Dout[WIDTH-1]} (the MSB wraps into the LSB), and CNT <= CNT-1.
  - When CNT == 1 at the edge, that edge performs the last rotation and the next state is DONE.
  - LOAD and ACK are ignored.
  - Din and AMT are not re-sampled.
- **DONE**
  - Dout holds the result.
  - LOAD=1: behaves exactly as LOAD in IDLE, starting a new operation. LOAD has priority over ACK.
  - LOAD=0 and ACK=1: next state is IDLE, and Dout keeps its value.
  - Otherwise the state holds.
- Final Dout = rotate-left(Din, AMT). Equivalently, it is the inverse of a right rotation by AMT.
- No arithmetic beyond the CNT decrement. CNT never wraps, because the ROTATE exit happens at CNT == 1.

## Timing
- Reset, asynchronous and taking effect immediately:
  - state = IDLE, Dout = 0, CNT = 0.
  - BUSY = 0, DONE = 0.
- Latency, with LOAD sampled at edge k:
  - Dout = Din after edge k.
  - DONE = 1 after edge k+AMT. For AMT=0 this is edge k.
  - BUSY = 1 from after edge k through edge k+AMT-1. For AMT=0, BUSY never rises.
- After edge k+j, for 0 ≤ j ≤ AMT, Dout = rotate-left(Din, j). This gives one visible rotation per cycle.
- DONE stays high until the edge that samples ACK=1 or LOAD=1.
- Back-to-back operation: LOAD in DONE at edge m makes Dout = new Din after edge m, with no idle bubble.
- RST asserted mid-ROTATE or in DONE aborts the operation immediately and returns to the reset values. The first LOAD after RST deasserts is accepted normally.

## Test plan
- Reset: assert RST mid-cycle -> Dout=0x00, BUSY=0 and DONE=0 before the next edge.
- LOAD Din=0xB4, AMT=3 -> Dout steps 0xB4, 0x69, 0xD2, 0xA5 on successive edges. BUSY is high for 3 cycles; DONE rises with 0xA5. ACK -> IDLE, with Dout=0xA5 held.
- LOAD Din=0x3C, AMT=0 -> Dout=0x3C and DONE=1 one edge after LOAD; BUSY never asserts.
- LOAD Din=0x01, AMT=7 -> after 7 rotation edges Dout=0x80 and DONE=1. A LOAD of Din=0xFF, AMT=2 issued during ROTATE is ignored.
- In DONE, apply LOAD=1 (Din=0x81, AMT=1) and ACK=1 together -> the load wins: Dout=0x81, then 0x03 with DONE=1.
- Assert RST during ROTATE of Din=0xF0, AMT=5 at cycle 2 -> immediate return to IDLE with Dout=0. A following LOAD of Din=0x0F, AMT=4 yields 0xF0 with DONE.
